// File: rtl/cr16_alu_seq.sv
// Registered CR16 ALU with a stored carry flag and an iterative shift-add multiplier.
// Single-cycle ops complete on the accepting edge; MUL holds O_READY low for WIDTH edges.
module cr16_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             I_CLK,
    input  logic             I_NRESET,
    input  logic             I_ENABLE,
    input  logic             I_VALID,
    input  logic [3:0]       I_OPCODE,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    output logic             O_READY,
    output logic             O_VALID,
    output logic [WIDTH-1:0] O_C,
    output logic [WIDTH-1:0] O_C_HI,
    output logic [4:0]       O_STATUS
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDU  = 4'd1;
    localparam logic [3:0] OP_ADDC  = 4'd2;
    localparam logic [3:0] OP_ADDCU = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_LSH   = 4'd10;
    localparam logic [3:0] OP_RSH   = 4'd11;
    localparam logic [3:0] OP_ALSH  = 4'd12;
    localparam logic [3:0] OP_ARSH  = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_CMP   = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     c_q, c_d;
    logic [WIDTH-1:0]     c_hi_q, c_hi_d;
    logic [4:0]           status_q, status_d;
    logic                 valid_q, valid_d;
    logic                 cflag_q, cflag_d;

    logic                 cin;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic                 shift_big;
    logic [SHAMT_W-1:0]   shamt;
    logic [2*WIDTH-1:0]   prod_next;

    logic [WIDTH-1:0]     alu_c;
    logic                 alu_n, alu_z, alu_f, alu_l, alu_cy, alu_cflag_we;

    assign cin       = ((I_OPCODE == OP_ADDC) || (I_OPCODE == OP_ADDCU)) ? cflag_q : 1'b0;
    assign add_sum   = {1'b0, I_A} + {1'b0, I_B} + {{WIDTH{1'b0}}, cin};
    // B - A; the extra top bit is the unsigned borrow, i.e. B < A.
    assign sub_diff  = {1'b0, I_B} - {1'b0, I_A};
    assign shift_big = (I_B >= WIDTH_V);
    assign shamt     = I_B[SHAMT_W-1:0];
    assign prod_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    always_comb begin
        alu_c        = c_q;
        alu_n        = 1'b0;
        alu_f        = 1'b0;
        alu_l        = 1'b0;
        alu_cy       = 1'b0;
        alu_cflag_we = 1'b0;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                alu_c = add_sum[WIDTH-1:0];
                alu_n = add_sum[WIDTH-1];
                alu_f = (I_A[WIDTH-1] == I_B[WIDTH-1]) && (add_sum[WIDTH-1] != I_A[WIDTH-1]);
            end
            OP_ADDU, OP_ADDCU: begin
                alu_c        = add_sum[WIDTH-1:0];
                alu_cy       = add_sum[WIDTH];
                alu_cflag_we = 1'b1;
            end
            OP_SUB: begin
                alu_c = sub_diff[WIDTH-1:0];
                alu_n = sub_diff[WIDTH-1];
                alu_f = (I_A[WIDTH-1] != I_B[WIDTH-1]) && (sub_diff[WIDTH-1] != I_B[WIDTH-1]);
            end
            OP_SUBU: begin
                alu_c        = sub_diff[WIDTH-1:0];
                alu_cy       = sub_diff[WIDTH];
                alu_l        = sub_diff[WIDTH];
                alu_cflag_we = 1'b1;
            end
            OP_AND:  alu_c = I_A & I_B;
            OP_OR:   alu_c = I_A | I_B;
            OP_XOR:  alu_c = I_A ^ I_B;
            OP_NOT:  alu_c = ~I_A;
            OP_LSH, OP_ALSH: alu_c = shift_big ? {WIDTH{1'b0}} : (I_A << shamt);
            OP_RSH:  alu_c = shift_big ? {WIDTH{1'b0}} : (I_A >> shamt);
            OP_ARSH: alu_c = shift_big ? {WIDTH{I_A[WIDTH-1]}} : ($signed(I_A) >>> shamt);
            OP_CMP: begin
                alu_l = sub_diff[WIDTH];
                alu_n = ($signed(I_B) < $signed(I_A));
            end
            default: ;
        endcase
        alu_z = (I_OPCODE == OP_CMP) ? (I_A == I_B) : (alu_c == {WIDTH{1'b0}});
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        c_d      = c_q;
        c_hi_d   = c_hi_q;
        status_d = status_q;
        valid_d  = 1'b0;
        cflag_d  = cflag_q;
        case (state_q)
            ST_IDLE: begin
                if (I_VALID) begin
                    if (I_OPCODE == OP_MUL) begin
                        state_d  = ST_BUSY;
                        cnt_d    = SHAMT_W'(WIDTH - 1);
                        mcand_d  = {{WIDTH{1'b0}}, I_A};
                        mplier_d = I_B;
                        acc_d    = {(2*WIDTH){1'b0}};
                    end else begin
                        c_d      = alu_c;
                        c_hi_d   = {WIDTH{1'b0}};
                        status_d = {alu_n, alu_z, alu_f, alu_l, alu_cy};
                        valid_d  = 1'b1;
                        if (alu_cflag_we) begin
                            cflag_d = alu_cy;
                        end
                    end
                end
            end
            ST_BUSY: begin
                // One partial product per cycle: multiplicand walks left, multiplier right.
                acc_d    = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == {SHAMT_W{1'b0}}) begin
                    state_d  = ST_IDLE;
                    c_d      = prod_next[WIDTH-1:0];
                    c_hi_d   = prod_next[2*WIDTH-1:WIDTH];
                    status_d = {1'b0, (prod_next == {(2*WIDTH){1'b0}}), 1'b0, 1'b0,
                                (prod_next[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}})};
                    valid_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= ST_IDLE;
        end else if (I_ENABLE) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            cnt_q    <= {SHAMT_W{1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            c_q      <= {WIDTH{1'b0}};
            c_hi_q   <= {WIDTH{1'b0}};
            status_q <= 5'd0;
            valid_q  <= 1'b0;
            cflag_q  <= 1'b0;
        end else if (I_ENABLE) begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            c_hi_q   <= c_hi_d;
            status_q <= status_d;
            valid_q  <= valid_d;
            cflag_q  <= cflag_d;
        end
    end

    assign O_READY  = (state_q == ST_IDLE);
    assign O_VALID  = valid_q;
    assign O_C      = c_q;
    assign O_C_HI   = c_hi_q;
    assign O_STATUS = status_q;

endmodule

// File: tb/tb_cr16_alu_seq.sv
// Bench for cr16_alu_seq: directed vectors plus random traffic against an arithmetic reference model.
// A 16-bit instance carries most traffic; a 32-bit instance covers the stalled multiply.
module tb_cr16_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, vld;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        rdy, ov;
    logic [15:0] oc, ochi;
    logic [4:0]  ost;

    logic        en32, vld32;
    logic [3:0]  op32;
    logic [31:0] a32, b32;
    logic        rdy32, ov32;
    logic [31:0] oc32, ochi32;
    logic [4:0]  ost32;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: last result word and stored carry.
    logic [15:0] m_c;
    logic        m_cflag;

    always #5 clk = ~clk;

    cr16_alu_seq #(.WIDTH(16)) dut16 (
        .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(en), .I_VALID(vld), .I_OPCODE(op),
        .I_A(a), .I_B(b), .O_READY(rdy), .O_VALID(ov), .O_C(oc), .O_C_HI(ochi),
        .O_STATUS(ost)
    );

    cr16_alu_seq #(.WIDTH(32)) dut32 (
        .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(en32), .I_VALID(vld32), .I_OPCODE(op32),
        .I_A(a32), .I_B(b32), .O_READY(rdy32), .O_VALID(ov32), .O_C(oc32), .O_C_HI(ochi32),
        .O_STATUS(ost32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] ec, output logic [15:0] ehi, output logic [4:0] est);
        int sx, sy, r, sh, cf;
        logic [31:0] p;
        logic n, z, f, l, cy;
        sx = $signed(x);
        sy = $signed(y);
        sh = y;
        cf = m_cflag ? 1 : 0;
        ec = m_c; ehi = 16'h0;
        n = 0; f = 0; l = 0; cy = 0;
        case (o)
            4'd0, 4'd2: begin
                r = sx + sy + ((o == 4'd2) ? cf : 0);
                ec = r[15:0]; f = (r > 32767) || (r < -32768); n = ec[15];
            end
            4'd1, 4'd3: begin
                r = x + y + ((o == 4'd3) ? cf : 0);
                ec = r[15:0]; cy = (r > 65535); m_cflag = cy;
            end
            4'd4: begin
                r = sy - sx;
                ec = r[15:0]; f = (r > 32767) || (r < -32768); n = ec[15];
            end
            4'd5: begin
                ec = y - x; cy = (y < x); l = cy; m_cflag = cy;
            end
            4'd6: ec = x & y;
            4'd7: ec = x | y;
            4'd8: ec = x ^ y;
            4'd9: ec = ~x;
            4'd10, 4'd12: ec = (sh >= 16) ? 16'h0 : (x << sh);
            4'd11: ec = (sh >= 16) ? 16'h0 : (x >> sh);
            4'd13: begin
                r = sx >>> ((sh >= 16) ? 15 : sh);
                ec = r[15:0];
            end
            4'd14: begin
                p = x * y;
                ec = p[15:0]; ehi = p[31:16]; cy = (ehi != 16'h0);
            end
            default: begin
                l = (y < x); n = (sy < sx);
            end
        endcase
        if (o == 4'd15) z = (x == y);
        else if (o == 4'd14) z = (ec == 16'h0) && (ehi == 16'h0);
        else z = (ec == 16'h0);
        m_c = ec;
        est = {n, z, f, l, cy};
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] ec, ehi;
        logic [4:0]  est;
        @(negedge clk);
        op = o; a = x; b = y; vld = 1'b1;
        @(posedge clk);
        #1;
        model(o, x, y, ec, ehi, est);
        chk($sformatf("op%0d_valid", o), {63'd0, ov}, 64'd1);
        chk($sformatf("op%0d_c a=%0h b=%0h", o, x, y), {48'd0, oc}, {48'd0, ec});
        chk($sformatf("op%0d_hi", o), {48'd0, ochi}, {48'd0, ehi});
        chk($sformatf("op%0d_status a=%0h b=%0h", o, x, y), {59'd0, ost}, {59'd0, est});
        chk($sformatf("op%0d_ready", o), {63'd0, rdy}, 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic do_mul(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] ec, ehi;
        logic [4:0]  est;
        int edges;
        logic busy_ok;
        @(negedge clk);
        op = 4'd14; a = x; b = y; vld = 1'b1;
        @(posedge clk);
        #1;
        chk("mul_ready_drop", {63'd0, rdy}, 64'd0);
        chk("mul_no_valid_at_accept", {63'd0, ov}, 64'd0);
        // Offer a different request while busy; it must be dropped.
        op = 4'd0; a = 16'h1234; b = 16'h0101; vld = 1'b1;
        edges = 0;
        busy_ok = 1'b1;
        while (ov !== 1'b1 && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (ov !== 1'b1 && rdy !== 1'b0) busy_ok = 1'b0;
            if (edges == 3) vld = 1'b0;
        end
        model(4'd14, x, y, ec, ehi, est);
        chk("mul_latency", 64'(edges), 64'd16);
        chk("mul_busy_ready_low", {63'd0, busy_ok}, 64'd1);
        chk($sformatf("mul_c %0h*%0h", x, y), {48'd0, oc}, {48'd0, ec});
        chk($sformatf("mul_hi %0h*%0h", x, y), {48'd0, ochi}, {48'd0, ehi});
        chk("mul_status", {59'd0, ost}, {59'd0, est});
        chk("mul_ready_back", {63'd0, rdy}, 64'd1);
        @(posedge clk);
        #1;
        chk("mul_valid_one_cycle", {63'd0, ov}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        logic [3:0]  ro;
        logic [15:0] ra, rb;
        logic        saw_valid;

        rst_n = 1'b0; en = 1'b1; vld = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0;
        en32 = 1'b1; vld32 = 1'b0; op32 = 4'd0; a32 = 32'h0; b32 = 32'h0;
        m_c = 16'h0; m_cflag = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_c", {48'd0, oc}, 64'd0);
        chk("rst_hi", {48'd0, ochi}, 64'd0);
        chk("rst_status", {59'd0, ost}, 64'd0);
        chk("rst_valid", {63'd0, ov}, 64'd0);
        chk("rst_ready", {63'd0, rdy}, 64'd1);
        chk("rst_ready32", {63'd0, rdy32}, 64'd1);

        // Carry chain: ADDU sets cflag, ADDCU consumes it.
        issue(4'd1, 16'hFFFF, 16'h0001);
        chk("addu_c_const", {48'd0, oc}, 64'h0000);
        chk("addu_st_const", {59'd0, ost}, 64'b01001);
        issue(4'd3, 16'h0000, 16'h0000);
        chk("addcu_c_const", {48'd0, oc}, 64'h0001);
        chk("addcu_st_const", {59'd0, ost}, 64'b00000);
        issue(4'd4, 16'h0001, 16'h8000);
        chk("sub_c_const", {48'd0, oc}, 64'h7FFF);
        chk("sub_st_const", {59'd0, ost}, 64'b00100);
        issue(4'd5, 16'h0005, 16'h0003);
        chk("subu_c_const", {48'd0, oc}, 64'hFFFE);
        chk("subu_st_const", {59'd0, ost}, 64'b00011);
        issue(4'd13, 16'h8000, 16'd20);
        chk("arsh_big_const", {48'd0, oc}, 64'hFFFF);
        issue(4'd11, 16'h8000, 16'd15);
        chk("rsh15_const", {48'd0, oc}, 64'h0001);
        issue(4'd10, 16'h8001, 16'd16);
        chk("lsh16_const", {48'd0, oc}, 64'h0000);
        issue(4'd12, 16'h00F1, 16'd4);
        issue(4'd15, 16'h0005, 16'hFFFB);
        issue(4'd15, 16'h1234, 16'h1234);
        issue(4'd2, 16'h7FFF, 16'h0000);
        issue(4'd0, 16'h7FFF, 16'h0001);
        idle();

        do_mul(16'hFFFF, 16'hFFFF);
        chk("mul_c_const", {48'd0, oc}, 64'h0001);
        chk("mul_hi_const", {48'd0, ochi}, 64'hFFFE);
        chk("mul_st_const", {59'd0, ost}, 64'b00001);
        do_mul(16'h0000, 16'hBEEF);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            if (ro == 4'd14) ro = 4'd15;
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom_range(0, 20));
                1: rb = ra;
                default: rb = 16'($urandom);
            endcase
            issue(ro, ra, rb);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            do_mul(16'($urandom), 16'($urandom));
        end
        issue(4'd15, 16'h0001, 16'h0002);
        idle();

        // Wide multiply with three stalled cycles mid-operation.
        @(negedge clk);
        op32 = 4'd14; a32 = 32'd7; b32 = 32'd6; vld32 = 1'b1;
        @(posedge clk);
        #1;
        vld32 = 1'b0;
        chk("mul32_ready_drop", {63'd0, rdy32}, 64'd0);
        edges = 0;
        while (ov32 !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 5) en32 = 1'b0;
            if (edges == 8) en32 = 1'b1;
        end
        chk("mul32_latency", 64'(edges), 64'd35);
        chk("mul32_c", {32'd0, oc32}, 64'd42);
        chk("mul32_hi", {32'd0, ochi32}, 64'd0);
        chk("mul32_status", {59'd0, ost32}, 64'd0);

        // Reset during the fifth busy cycle aborts the multiply.
        @(negedge clk);
        op = 4'd14; a = 16'h00FF; b = 16'h00FF; vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_c = 16'h0; m_cflag = 1'b0;
        chk("abort_ready", {63'd0, rdy}, 64'd1);
        chk("abort_valid", {63'd0, ov}, 64'd0);
        chk("abort_c", {48'd0, oc}, 64'd0);
        chk("abort_hi", {48'd0, ochi}, 64'd0);
        chk("abort_status", {59'd0, ost}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ov === 1'b1) saw_valid = 1'b1;
        end
        chk("abort_no_valid", {63'd0, saw_valid}, 64'd0);
        issue(4'd0, 16'h1111, 16'h2222);
        issue(4'd3, 16'h0001, 16'h0001);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
